// File: rtl/cs_bus_pkg.sv
// Shared types and sizing helpers for the 68k bus-cycle sequencer.
// Used by cs_cycle_ctrl and its chipselect decoder.
package cs_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACK,
        BERR
    } cs_state_t;

    localparam int CFG_WAIT_W = 4;
    localparam int TIMEOUT_W  = 8;

    typedef struct packed {
        logic [CFG_WAIT_W-1:0] wait_cnt;
        logic                  rdy_mode;
    } cs_cfg_t;

    function automatic int sel_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Timeout counter is never narrower than TIMEOUT_W bits.
    function automatic int timeout_bits(input int cycles);
        return ($clog2(cycles) > TIMEOUT_W) ? $clog2(cycles) : TIMEOUT_W;
    endfunction

endpackage

// File: rtl/cs_cycle_ctrl_dec.sv
// Chipselect decoder: turns a region index (top address bits) into a
// one-hot select vector.
module cs_cycle_ctrl_dec
    import cs_bus_pkg::*;
#(
    parameter int NUM_SELECTS = 8,
    localparam int SB = sel_bits(NUM_SELECTS)
) (
    input  logic [SB-1:0]          idx,
    output logic [NUM_SELECTS-1:0] sel
);

    always_comb begin
        sel      = '0;
        sel[idx] = 1'b1;
    end

endmodule

// File: rtl/cs_cycle_ctrl.sv
// Bus-cycle sequencer: chip select, programmable wait states, DTACK.
// Optional bus-error timeout enabled by defining BERR_TIMEOUT_EN.
module cs_cycle_ctrl
    import cs_bus_pkg::*;
#(
    parameter int NUM_SELECTS    = 8,
    parameter int WAIT_W         = 4,
    parameter int DEFAULT_WAIT   = 2,
    parameter int TIMEOUT_CYCLES = 256,
    localparam int SB = sel_bits(NUM_SELECTS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   as_n,
    input  logic [31:0]            addr,
    input  logic [NUM_SELECTS-1:0] ext_ready,
    input  logic                   cfg_we,
    input  logic [SB-1:0]          cfg_idx,
    input  logic [WAIT_W-1:0]      cfg_wait,
    input  logic                   cfg_rdy_mode,
    output logic [NUM_SELECTS-1:0] chipselects,
    output logic                   dtack_n,
    output logic                   berr_n,
    output logic                   busy
);

    cs_state_t               state;
    logic [SB-1:0]           idx;
    logic [WAIT_W-1:0]       wcnt;
    logic                    rdy;
    logic                    as_q;
    logic [WAIT_W-1:0]       wait_cfg [NUM_SELECTS];
    logic [NUM_SELECTS-1:0]  rdy_cfg;
    logic [SB-1:0]           start_idx;
    logic [NUM_SELECTS-1:0]  start_sel;
    logic                    unused_addr;
    logic                    done;

    assign start_idx   = addr[31 -: SB];
    assign unused_addr = ^addr[31-SB:0];
    assign done        = (wcnt == '0) && (!rdy || ext_ready[idx]);

    cs_cycle_ctrl_dec #(
        .NUM_SELECTS(NUM_SELECTS)
    ) u_dec (
        .idx(start_idx),
        .sel(start_sel)
    );

    // Config writes land on the edge; a cycle starting on the same
    // edge still captures the previous value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_SELECTS; i++)
                wait_cfg[i] <= WAIT_W'(DEFAULT_WAIT);
            rdy_cfg <= '0;
        end else if (cfg_we) begin
            wait_cfg[cfg_idx] <= cfg_wait;
            rdy_cfg[cfg_idx]  <= cfg_rdy_mode;
        end
    end

`ifdef BERR_TIMEOUT_EN
    localparam int TW = timeout_bits(TIMEOUT_CYCLES);
    logic [TW-1:0] tcnt;
    logic          berr_q;

    assign berr_n = berr_q;
`else
    assign berr_n = 1'b1;
`endif

    // A new cycle needs as_n seen high on the previous edge, so a strobe
    // held low across the end of a cycle never restarts it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            idx         <= '0;
            wcnt        <= '0;
            rdy         <= 1'b0;
            as_q        <= 1'b0;
            chipselects <= '0;
            dtack_n     <= 1'b1;
            busy        <= 1'b0;
`ifdef BERR_TIMEOUT_EN
            tcnt        <= '0;
            berr_q      <= 1'b1;
`endif
        end else begin
            as_q <= as_n;
            unique case (state)
                IDLE: begin
                    if (!as_n && as_q) begin
                        state       <= WAIT;
                        idx         <= start_idx;
                        wcnt        <= wait_cfg[start_idx];
                        rdy         <= rdy_cfg[start_idx];
                        chipselects <= start_sel;
                        busy        <= 1'b1;
`ifdef BERR_TIMEOUT_EN
                        tcnt        <= '0;
`endif
                    end
                end
                WAIT: begin
                    if (as_n) begin
                        state       <= IDLE;
                        chipselects <= '0;
                        busy        <= 1'b0;
                    end else if (done) begin
                        state   <= ACK;
                        dtack_n <= 1'b0;
`ifdef BERR_TIMEOUT_EN
                    end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        state  <= BERR;
                        berr_q <= 1'b0;
`endif
                    end else begin
                        if (wcnt != '0)
                            wcnt <= wcnt - 1'b1;
`ifdef BERR_TIMEOUT_EN
                        tcnt <= tcnt + 1'b1;
`endif
                    end
                end
                ACK: begin
                    if (as_n) begin
                        state       <= IDLE;
                        chipselects <= '0;
                        dtack_n     <= 1'b1;
                        busy        <= 1'b0;
                    end
                end
                BERR: begin
                    if (as_n) begin
                        state       <= IDLE;
                        chipselects <= '0;
                        busy        <= 1'b0;
`ifdef BERR_TIMEOUT_EN
                        berr_q      <= 1'b1;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cs_cycle_ctrl.sv
// Randomized bench for cs_cycle_ctrl against a transaction-level model,
// plus directed cycles with hand-computed latencies.
module tb_cs_cycle_ctrl;
    import cs_bus_pkg::*;

    localparam int NS = 8;
    localparam int TO = 16;

    logic           clk = 1'b0;
    logic           reset;
    logic           as_n;
    logic [31:0]    addr;
    logic [NS-1:0]  ext_ready;
    logic           cfg_we;
    logic [2:0]     cfg_idx;
    logic [3:0]     cfg_wait;
    logic           cfg_rdy_mode;
    logic [NS-1:0]  chipselects;
    logic           dtack_n;
    logic           berr_n;
    logic           busy;

    int pass_cnt = 0;
    int total    = 0;

    cs_cycle_ctrl #(
        .NUM_SELECTS(NS),
        .WAIT_W(4),
        .DEFAULT_WAIT(2),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .as_n(as_n),
        .addr(addr),
        .ext_ready(ext_ready),
        .cfg_we(cfg_we),
        .cfg_idx(cfg_idx),
        .cfg_wait(cfg_wait),
        .cfg_rdy_mode(cfg_rdy_mode),
        .chipselects(chipselects),
        .dtack_n(dtack_n),
        .berr_n(berr_n),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got === exp)
            pass_cnt++;
        else
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    endtask

    // Transaction-level model: a cycle is a start edge, a captured
    // config and an edge count; outputs follow from that count.
    cs_cfg_t cfg [NS];
    bit      act, acked, berred, prev_as;
    int      e, cur_idx;
    cs_cfg_t cur;
    bit      to_en;

    initial begin
`ifdef BERR_TIMEOUT_EN
        to_en = 1'b1;
`else
        to_en = 1'b0;
`endif
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            act = 0; acked = 0; berred = 0; prev_as = 0; e = 0; cur_idx = 0;
            for (int i = 0; i < NS; i++) cfg[i] = '{wait_cnt: 4'd2, rdy_mode: 1'b0};
        end else begin
            if (!act) begin
                if (!as_n && prev_as) begin
                    act = 1; acked = 0; berred = 0; e = 0;
                    cur_idx = int'(addr[31:29]);
                    cur = cfg[cur_idx];
                end
            end else begin
                e++;
                if (as_n) begin
                    act = 0; acked = 0; berred = 0;
                end else if (!acked && !berred) begin
                    if (e >= int'(cur.wait_cnt) + 1 &&
                        (!cur.rdy_mode || ext_ready[cur_idx]))
                        acked = 1;
                    else if (to_en && e >= TO)
                        berred = 1;
                end
            end
            if (cfg_we) cfg[cfg_idx] = '{wait_cnt: cfg_wait, rdy_mode: cfg_rdy_mode};
            prev_as = as_n;
        end
    end

    logic [NS-1:0] exp_cs;
    always @(negedge clk) begin
        if (!reset) begin
            exp_cs = act ? (NS'(1) << cur_idx) : '0;
            chk("cycle", {chipselects, dtack_n, berr_n, busy},
                {exp_cs, !(act && acked), !(act && berred), act});
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic cfg_write(input int i, input int w, input bit r);
        cfg_we = 1; cfg_idx = 3'(i); cfg_wait = 4'(w); cfg_rdy_mode = r;
        tick();
        cfg_we = 0;
    endtask

    task automatic start(input logic [31:0] a);
        as_n = 0; addr = a;
        tick();
    endtask

    task automatic wait_resp(output int n);
        n = 1;
        while (dtack_n && berr_n && n < 64) begin
            tick();
            n++;
        end
    endtask

    task automatic release_bus();
        as_n = 1;
        tick();
        tick();
    endtask

    int n;

    initial begin
        reset = 1; as_n = 1; addr = '0; ext_ready = '0;
        cfg_we = 0; cfg_idx = '0; cfg_wait = '0; cfg_rdy_mode = 0;
        #23;
        chk("reset_outs", {chipselects, dtack_n, berr_n, busy}, {8'h00, 3'b110});
        tick();
        reset = 0;
        tick(); tick();

        // default wait of 2: select on the first edge, dtack on edge 4
        start(32'h6000_0000);
        chk("t1_cs", chipselects, 8'h08);
        wait_resp(n);
        chk("t1_lat", n, 4);
        as_n = 1;
        tick();
        chk("t1_clear", {chipselects, dtack_n}, {8'h00, 1'b1});
        tick();

        cfg_write(3, 0, 0);
        tick();
        start(32'h6000_0000);
        wait_resp(n);
        chk("t2_lat0", n, 2);
        release_bus();
        start(32'h2000_0000);
        wait_resp(n);
        chk("t2_lat_other", n, 4);
        release_bus();

        cfg_write(7, 0, 1);
        ext_ready = '0;
        tick();
        start(32'hE000_0000);
        for (int i = 0; i < 5; i++) begin
            chk("t3_hold", {chipselects, dtack_n}, {8'h80, 1'b1});
            tick();
        end
        ext_ready = 8'h80;
        tick();
        chk("t3_ack", {chipselects, dtack_n}, {8'h80, 1'b0});
        ext_ready = '0;
        release_bus();

        cfg_write(2, 5, 0);
        tick();
        start(32'h4000_0000);
        tick();
        as_n = 1;
        tick();
        chk("t4_abort", {chipselects, dtack_n, busy}, {8'h00, 1'b1, 1'b0});
        tick();

        cfg_write(5, 0, 1);
        ext_ready = '0;
        tick();
        start(32'hA000_0000);
`ifdef BERR_TIMEOUT_EN
        wait_resp(n);
        chk("t5_berr_lat", n, TO + 1);
        chk("t5_berr", {berr_n, dtack_n}, 2'b01);
`else
        repeat (20) tick();
        chk("t5_stall", {berr_n, dtack_n, busy}, 3'b111);
`endif
        release_bus();

        cfg_write(4, 0, 0);
        tick();
        start(32'h8000_0000);
        wait_resp(n);
        chk("t6_pre", n, 2);
        @(posedge clk);
        #2 reset = 1;
        #1 chk("t6_async", {chipselects, dtack_n, busy}, {8'h00, 1'b1, 1'b0});
        tick();
        as_n = 1;
        tick();
        reset = 0;
        tick(); tick();
        start(32'h8000_0000);
        wait_resp(n);
        chk("t6_default", n, 4);
        release_bus();

        // randomized traffic with config writes, aborts and ready noise
        for (int t = 0; t < 250; t++) begin
            int ab, k;
            ab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 6)) : 1000;
            as_n = 0;
            addr = $urandom;
            k = 0;
            do begin
                ext_ready = 8'($urandom);
                cfg_we = ($urandom_range(0, 3) == 0);
                cfg_idx = 3'($urandom);
                cfg_wait = 4'($urandom_range(0, 6));
                cfg_rdy_mode = ($urandom_range(0, 2) == 0);
                tick();
                k++;
            end while (dtack_n && berr_n && k < ab && k < 40);
            cfg_we = 0;
            repeat ($urandom_range(0, 2)) tick();
            as_n = 1;
            repeat ($urandom_range(1, 3)) begin
                ext_ready = 8'($urandom);
                tick();
            end
        end

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
